// File: rtl/dm_lsu.sv
// Data-memory load/store unit: byte-addressed, big-endian lanes, sign/zero-extended
// sub-word loads, misalignment flagging and an optional post-reset zero sweep.
module dm_lsu #(
  parameter int ADDR_WIDTH     = 10,
  parameter int RD_LATENCY     = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [1:0] WAIT_LOAD = (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;

  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

  state_t                  state, state_nx;
  logic [31:0]             mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   clr_idx;
  logic [1:0]              wait_cnt;
  logic [31:0]             data_q;
  logic                    err_q;

  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [1:0]              byte_off;
  logic [31:0]             rd_word;
  logic                    accept;
  logic                    misaligned;
  logic [3:0]              lane_be;
  logic [31:0]             store_word;
  logic [31:0]             load_ext;
  logic [7:0]              sel_byte;
  logic [15:0]             sel_half;

  assign word_idx = req_addr[ADDR_WIDTH+1:2];
  assign byte_off = req_addr[1:0];
  assign rd_word  = mem[word_idx];
  assign accept   = (state == IDLE) && req_valid;

  // Lane decode: lane_be[3] is bits [31:24], i.e. byte offset 0 (big-endian).
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    misaligned = 1'b0;
    lane_be    = 4'b0000;
    store_word = '0;
    load_ext   = '0;
    sel_byte   = '0;
    case (byte_off)
      2'd0:    sel_byte = rd_word[31:24];
      2'd1:    sel_byte = rd_word[23:16];
      2'd2:    sel_byte = rd_word[15:8];
      default: sel_byte = rd_word[7:0];
    endcase
    sel_half = byte_off[1] ? rd_word[15:0] : rd_word[31:16];
    case (req_size)
      2'b00: begin
        lane_be    = 4'b1000 >> byte_off;
        store_word = {4{req_wdata[7:0]}};
        load_ext   = req_unsigned ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      end
      2'b01: begin
        misaligned = byte_off[0];
        lane_be    = byte_off[1] ? 4'b0011 : 4'b1100;
        store_word = {2{req_wdata[15:0]}};
        load_ext   = req_unsigned ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
      end
      2'b10: begin
        misaligned = |byte_off;
        lane_be    = 4'b1111;
        store_word = req_wdata;
        load_ext   = rd_word;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // NOTE: the array has no reset; zeroing it is the INIT sweep's job, one word
  // per cycle, which keeps it mappable onto RAM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[clr_idx] <= '0;
      end else if (accept && req_we && !misaligned) begin
        for (int i = 0; i < 4; i++) begin
          if (lane_be[i]) mem[word_idx][8*i +: 8] <= store_word[8*i +: 8];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= (CLEAR_ON_RESET != 0) ? INIT : IDLE;
      clr_idx  <= '0;
      wait_cnt <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == INIT) clr_idx <= clr_idx + 1'b1;
      if (accept) begin
        data_q   <= (req_we || misaligned) ? 32'd0 : load_ext;
        err_q    <= misaligned;
        wait_cnt <= WAIT_LOAD;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      INIT: if (&clr_idx) state_nx = IDLE;
      IDLE: begin
        if (req_valid) begin
          if (req_we || misaligned || RD_LATENCY <= 1) state_nx = RESP;
          else                                         state_nx = WAIT;
        end
      end
      WAIT: if (wait_cnt == 2'd0) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rsp_valid ? data_q : 32'd0;
  assign rsp_err   = rsp_valid & err_q;

endmodule

// File: tb/tb_dm_lsu.sv
// Self-checking bench for dm_lsu: a default instance (sweep, latency 1) and a
// latency-3 instance without sweep, checked through a response scoreboard.
module tb_dm_lsu;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_we;
  logic [1:0][1:0]   req_size;
  logic [1:0]        req_unsigned;
  logic [1:0][11:0]  req_addr;
  logic [1:0][31:0]  req_wdata;
  logic [1:0]        rsp_valid;
  logic [1:0][31:0]  rsp_rdata;
  logic [1:0]        rsp_err;
  logic [1:0]        busy;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t q0[$];
  exp_t q1[$];

  dm_lsu #(.ADDR_WIDTH(10), .RD_LATENCY(1), .CLEAR_ON_RESET(1)) u_dut (
    .clk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  dm_lsu #(.ADDR_WIDTH(10), .RD_LATENCY(3), .CLEAR_ON_RESET(0)) u_lat (
    .clk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  // Scoreboard: every rsp_valid pulse must match the oldest expectation,
  // including the cycle it was due in.
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (rsp_valid[i]) begin
        checks++;
        if (qsize(i) == 0) begin
          failures++;
          $display("FAIL unexpected_rsp dut%0d: got rdata=%h err=%b, required no response",
                   i, rsp_rdata[i], rsp_err[i]);
        end else begin
          if (i == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          if (rsp_rdata[i] !== e.rdata || rsp_err[i] !== e.err || cyc !== e.due) begin
            failures++;
            $display("FAIL rsp dut%0d: got rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                     i, rsp_rdata[i], rsp_err[i], cyc, e.rdata, e.err, e.due);
          end
        end
      end
    end
  end

  // Drives one request, queues its expected response and waits for it to drain.
  task automatic issue(input int i, input logic we, input logic [1:0] size, input logic uns,
                       input logic [11:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    exp_t e;
    int   n;
    @(negedge clk);
    req_valid[i] = 1'b1; req_we[i] = we; req_size[i] = size; req_unsigned[i] = uns;
    req_addr[i] = addr; req_wdata[i] = wdata;
    checks++;
    if (req_ready[i] !== 1'b1) begin
      failures++;
      $display("FAIL ready_at_req dut%0d addr=%h: got %b, required 1", i, addr, req_ready[i]);
    end
    e.rdata = exp_rdata; e.err = exp_err; e.due = cyc + lat;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(negedge clk);
    req_valid[i] = 1'b0;
    n = 0;
    while (qsize(i) != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (qsize(i) != 0) begin
      failures++;
      $display("FAIL rsp_timeout dut%0d addr=%h: got no response, required one", i, addr);
      if (i == 0) q0.delete();
      else        q1.delete();
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 2'b11; req_valid = '0; req_we = '0; req_size = '0; req_unsigned = '0;
    req_addr = '0; req_wdata = '0;
    @(negedge clk);
    checks += 5;
    if (rsp_valid[0] !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid: got %b, required 0", rsp_valid[0]); end
    if (rsp_rdata[0] !== 32'd0) begin failures++; $display("FAIL rst_rsp_rdata: got %h, required 0", rsp_rdata[0]); end
    if (rsp_err[0] !== 1'b0) begin failures++; $display("FAIL rst_rsp_err: got %b, required 0", rsp_err[0]); end
    if (busy[0] !== 1'b1 || req_ready[0] !== 1'b0) begin
      failures++; $display("FAIL rst_init: got busy=%b ready=%b, required busy=1 ready=0", busy[0], req_ready[0]);
    end
    if (busy[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
      failures++; $display("FAIL rst_noclear: got busy=%b ready=%b, required busy=0 ready=1", busy[1], req_ready[1]);
    end
    rst = 2'b00;
    n = 0;
    while (busy[0] === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks += 2;
    if (n != 1024) begin failures++; $display("FAIL sweep_cycles: got %0d, required 1024", n); end
    if (req_ready[0] !== 1'b1) begin failures++; $display("FAIL ready_after_sweep: got %b, required 1", req_ready[0]); end
    issue(0, 1'b0, 2'b10, 1'b0, 12'hFFC, 32'd0, 32'h0000_0000, 1'b0, 1);
  endtask

  task automatic test_byte_lanes();
    logic [7:0] exp_b [4];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    issue(0, 1'b1, 2'b10, 1'b0, 12'h010, 32'h1122_3344, 32'd0, 1'b0, 1);
    for (int k = 0; k < 4; k++) begin
      issue(0, 1'b0, 2'b00, 1'b0, 12'h010 + 12'(k), 32'd0, {24'd0, exp_b[k]}, 1'b0, 1);
      issue(0, 1'b0, 2'b00, 1'b1, 12'h010 + 12'(k), 32'd0, {24'd0, exp_b[k]}, 1'b0, 1);
    end
    issue(0, 1'b1, 2'b00, 1'b0, 12'h014, 32'h0000_0080, 32'd0, 1'b0, 1);
    issue(0, 1'b0, 2'b00, 1'b0, 12'h014, 32'd0, 32'hFFFF_FF80, 1'b0, 1);
    issue(0, 1'b0, 2'b00, 1'b1, 12'h014, 32'd0, 32'h0000_0080, 1'b0, 1);
    issue(0, 1'b0, 2'b10, 1'b1, 12'h014, 32'd0, 32'h8000_0000, 1'b0, 1);
  endtask

  task automatic test_half();
    issue(0, 1'b1, 2'b10, 1'b0, 12'h020, 32'hAAAA_AAAA, 32'd0, 1'b0, 1);
    issue(0, 1'b1, 2'b01, 1'b0, 12'h022, 32'h0000_BEEF, 32'd0, 1'b0, 1);
    issue(0, 1'b0, 2'b10, 1'b0, 12'h020, 32'd0, 32'hAAAA_BEEF, 1'b0, 1);
    issue(0, 1'b0, 2'b01, 1'b0, 12'h022, 32'd0, 32'hFFFF_BEEF, 1'b0, 1);
    issue(0, 1'b0, 2'b01, 1'b1, 12'h022, 32'd0, 32'h0000_BEEF, 1'b0, 1);
    issue(0, 1'b0, 2'b01, 1'b0, 12'h020, 32'd0, 32'hFFFF_AAAA, 1'b0, 1);
  endtask

  task automatic test_errors();
    issue(0, 1'b0, 2'b01, 1'b0, 12'h021, 32'd0, 32'd0, 1'b1, 1);
    issue(0, 1'b1, 2'b10, 1'b0, 12'h006, 32'hDEAD_BEEF, 32'd0, 1'b1, 1);
    issue(0, 1'b0, 2'b10, 1'b0, 12'h013, 32'd0, 32'd0, 1'b1, 1);
    issue(0, 1'b0, 2'b11, 1'b0, 12'h020, 32'd0, 32'd0, 1'b1, 1);
    issue(0, 1'b1, 2'b11, 1'b0, 12'h020, 32'h1234_5678, 32'd0, 1'b1, 1);
    issue(0, 1'b0, 2'b10, 1'b0, 12'h004, 32'd0, 32'h0000_0000, 1'b0, 1);
    issue(0, 1'b0, 2'b10, 1'b0, 12'h020, 32'd0, 32'hAAAA_BEEF, 1'b0, 1);
  endtask

  task automatic test_latency();
    exp_t e;
    int   n;
    issue(1, 1'b1, 2'b10, 1'b0, 12'h008, 32'hCAFE_F00D, 32'd0, 1'b0, 1);
    issue(1, 1'b0, 2'b10, 1'b0, 12'h008, 32'd0, 32'hCAFE_F00D, 1'b0, 3);
    // Back-to-back: req_valid stays high across the whole first transaction.
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_size[1] = 2'b10; req_addr[1] = 12'h008;
    checks++;
    if (req_ready[1] !== 1'b1) begin failures++; $display("FAIL b2b_ready_k: got %b, required 1", req_ready[1]); end
    e.rdata = 32'hCAFE_F00D; e.err = 1'b0; e.due = cyc + 3;
    q1.push_back(e);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks += 2;
      if (req_ready[1] !== 1'b0) begin
        failures++; $display("FAIL b2b_ready_low step%0d: got %b, required 0", j, req_ready[1]);
      end
      if (rsp_valid[1] !== (j == 2)) begin
        failures++; $display("FAIL b2b_rsp_valid step%0d: got %b, required %b", j, rsp_valid[1], j == 2);
      end
    end
    @(negedge clk);
    checks++;
    if (req_ready[1] !== 1'b1) begin failures++; $display("FAIL b2b_ready_k4: got %b, required 1", req_ready[1]); end
    req_size[1] = 2'b00; req_unsigned[1] = 1'b0; req_addr[1] = 12'h009;
    e.rdata = 32'hFFFF_FFFE; e.err = 1'b0; e.due = cyc + 3;
    q1.push_back(e);
    @(negedge clk);
    checks++;
    if (req_ready[1] !== 1'b0) begin failures++; $display("FAIL b2b_second_accept: got ready=%b, required 0", req_ready[1]); end
    req_valid[1] = 1'b0;
    n = 0;
    while (q1.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q1.size() != 0) begin
      failures++; $display("FAIL b2b_timeout: got %0d pending, required 0", q1.size());
      q1.delete();
    end
  endtask

  task automatic test_reset_in_wait();
    issue(1, 1'b1, 2'b10, 1'b0, 12'h004, 32'h1234_5678, 32'd0, 1'b0, 1);
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_size[1] = 2'b10; req_addr[1] = 12'h004;
    @(negedge clk);
    req_valid[1] = 1'b0;
    checks++;
    if (busy[1] !== 1'b1) begin failures++; $display("FAIL wait_busy: got %b, required 1", busy[1]); end
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    #1;
    checks += 2;
    if (req_ready[1] !== 1'b1) begin failures++; $display("FAIL ready_after_rst: got %b, required 1", req_ready[1]); end
    if (busy[1] !== 1'b0) begin failures++; $display("FAIL busy_after_rst: got %b, required 0", busy[1]); end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid[1] !== 1'b0) begin
        failures++; $display("FAIL dropped_rsp step%0d: got rsp_valid=%b, required 0", j, rsp_valid[1]);
      end
    end
    issue(1, 1'b0, 2'b10, 1'b0, 12'h004, 32'd0, 32'h1234_5678, 1'b0, 3);
    issue(1, 1'b0, 2'b10, 1'b0, 12'h008, 32'd0, 32'hCAFE_F00D, 1'b0, 3);
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_half();
    test_errors();
    test_latency();
    test_reset_in_wait();
    repeat (4) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL leftover_expectations: got %0d/%0d, required 0/0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
